bp_cfg_boot_loader: RTL

Post-reset configuration sequencer that consumes the per-configuration processor parameters (core count, boot PC, coherence mode) and programs every core tile's configuration registers over a valid/ready command channel before releasing the cores from freeze. It sits between the top-level processor parameterisation and the per-tile configuration bus, ahead of any instruction fetch. It tracks outstanding writes with a credit counter and asserts `done_o` only after every write has been acknowledged.

---
 rtl/bp_cfg_boot_loader.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_cfg_boot_loader.sv
// -----------------------------------------------------------------------------
// bp_cfg_boot_loader
//
// Post-reset configuration sequencer. For every core tile it writes
// freeze=1, core_id, cce_mode and npc over a valid/ready command channel,
// waits until all of those writes are acknowledged, then writes freeze=0 to
// every core in order and raises done_o once the last acknowledgement has
// returned. Outstanding writes are bounded by a credit counter.
//
// Ports:
//   clk_i           clock
//   reset_i         synchronous active-high reset
//   cfg_v_o         configuration write valid (registered)
//   cfg_ready_i     downstream accepts the write this cycle
//   cfg_dst_o       destination core id (registered)
//   cfg_addr_o      configuration register address (registered)
//   cfg_data_o      configuration write data (registered)
//   cfg_ack_v_i     write acknowledgement, one per accepted write
//   cfg_ack_yumi_o  acknowledgement consumed (combinational, 0 in e_reset)
//   done_o          configuration complete, held until the next reset
//
// Also contains bp_cfg_boot_loader_checker, a protocol checker that watches
// the credit counter for acknowledgements arriving with nothing outstanding.
// -----------------------------------------------------------------------------
module bp_cfg_boot_loader #(
    parameter int unsigned num_core_p       = 32'd1,
    parameter int unsigned core_id_width_p  = 32'd4,
    parameter int unsigned cfg_addr_width_p = 32'd8,
    parameter int unsigned cfg_data_width_p = 32'd64,
    parameter logic [63:0] boot_pc_p        = 64'h0000_0000_8000_0000,
    parameter int unsigned cce_mode_p       = 32'd0,
    parameter int unsigned max_credits_p    = 32'd4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_id_width_p-1:0]  cfg_dst_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ack_v_i,
    output logic                        cfg_ack_yumi_o,
    output logic                        done_o
);

    localparam int unsigned credit_width_lp = $clog2(max_credits_p + 32'd1);
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);
    localparam logic [credit_width_lp-1:0] credit_zero_lp = {credit_width_lp{1'b0}};
    localparam logic [credit_width_lp-1:0] credit_one_lp  = credit_width_lp'(32'd1);
    localparam logic [core_id_width_p-1:0] last_core_lp   = core_id_width_p'(num_core_p - 32'd1);
    localparam logic [core_id_width_p-1:0] core_zero_lp   = {core_id_width_p{1'b0}};
    localparam logic [core_id_width_p-1:0] core_one_lp    = core_id_width_p'(32'd1);

    // Per-core write steps; the step index doubles as the register address.
    localparam logic [1:0] step_freeze_lp  = 2'd0;
    localparam logic [1:0] step_core_id_lp = 2'd1;
    localparam logic [1:0] step_cce_lp     = 2'd2;
    localparam logic [1:0] step_npc_lp     = 2'd3;

    localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp = cfg_addr_width_p'(8'h00);
    localparam logic [cfg_data_width_p-1:0] data_zero_lp   = {cfg_data_width_p{1'b0}};

    typedef enum logic [2:0] {
        e_reset         = 3'd0,
        e_send_cfg      = 3'd1,
        e_drain         = 3'd2,
        e_send_unfreeze = 3'd3,
        e_wait_acks     = 3'd4,
        e_done          = 3'd5
    } state_e;

    // Write data for one step of the per-core configuration block.
    function automatic logic [cfg_data_width_p-1:0] cfg_data_f(
        input logic [1:0]                 step,
        input logic [core_id_width_p-1:0] core
    );
        logic [cfg_data_width_p-1:0] data;
        case (step)
            step_freeze_lp:  data = cfg_data_width_p'(1'b1);
            step_core_id_lp: data = cfg_data_width_p'(core);
            step_cce_lp:     data = cfg_data_width_p'(cce_mode_p);
            step_npc_lp:     data = cfg_data_width_p'(boot_pc_p);
            default:         data = data_zero_lp;
        endcase
        return data;
    endfunction

    state_e                        state_r,  state_n_s;
    logic [core_id_width_p-1:0]    core_r,   core_n_s;
    logic [1:0]                    step_r,   step_n_s;
    logic [credit_width_lp-1:0]    credit_r, credit_n_s;
    logic                          cfg_v_r,  cfg_v_n_s;
    logic [core_id_width_p-1:0]    dst_r,    dst_n_s;
    logic [cfg_addr_width_p-1:0]   addr_r,   addr_n_s;
    logic [cfg_data_width_p-1:0]   data_r,   data_n_s;
    logic                          done_r,   done_n_s;
    logic                          xfer_s;
    logic                          ack_s;
    logic                          send_s;

    // Acks are consumed in every state except e_reset, so stale acks from an
    // aborted sequence never touch the fresh credit counter.
    assign cfg_ack_yumi_o = cfg_ack_v_i & (state_r != e_reset);

    assign cfg_v_o    = cfg_v_r;
    assign cfg_dst_o  = dst_r;
    assign cfg_addr_o = addr_r;
    assign cfg_data_o = data_r;
    assign done_o     = done_r;

    // Next-state, counter and output computation. Outputs are derived from the
    // next state/counters so they can be registered without adding latency.
    always_comb begin
        xfer_s     = cfg_v_r & cfg_ready_i;
        ack_s      = cfg_ack_yumi_o;
        state_n_s  = state_r;
        core_n_s   = core_r;
        step_n_s   = step_r;
        credit_n_s = credit_r;
        cfg_v_n_s  = 1'b0;
        dst_n_s    = core_zero_lp;
        addr_n_s   = addr_freeze_lp;
        data_n_s   = data_zero_lp;
        done_n_s   = 1'b0;
        send_s     = 1'b0;

        // Transfer and ack in the same cycle cancel; an ack with nothing
        // outstanding saturates at zero instead of wrapping.
        if (xfer_s && !ack_s) begin
            credit_n_s = credit_r + credit_one_lp;
        end else if (!xfer_s && ack_s && (credit_r != credit_zero_lp)) begin
            credit_n_s = credit_r - credit_one_lp;
        end else begin
            credit_n_s = credit_r;
        end

        case (state_r)
            e_reset: begin
                state_n_s = e_send_cfg;
                core_n_s  = core_zero_lp;
                step_n_s  = step_freeze_lp;
            end
            e_send_cfg: begin
                if (xfer_s) begin
                    if (step_r == step_npc_lp) begin
                        step_n_s = step_freeze_lp;
                        if (core_r == last_core_lp) begin
                            core_n_s  = core_zero_lp;
                            state_n_s = e_drain;
                        end else begin
                            core_n_s = core_r + core_one_lp;
                        end
                    end else begin
                        step_n_s = step_r + 2'd1;
                    end
                end else begin
                    state_n_s = e_send_cfg;
                end
            end
            e_drain: begin
                // Every core must hold a valid NPC before any core unfreezes.
                if (credit_r == credit_zero_lp) begin
                    state_n_s = e_send_unfreeze;
                end else begin
                    state_n_s = e_drain;
                end
            end
            e_send_unfreeze: begin
                if (xfer_s) begin
                    if (core_r == last_core_lp) begin
                        core_n_s  = core_zero_lp;
                        state_n_s = e_wait_acks;
                    end else begin
                        core_n_s = core_r + core_one_lp;
                    end
                end else begin
                    state_n_s = e_send_unfreeze;
                end
            end
            e_wait_acks: begin
                if (credit_r == credit_zero_lp) begin
                    state_n_s = e_done;
                end else begin
                    state_n_s = e_wait_acks;
                end
            end
            e_done: begin
                state_n_s = e_done;
            end
            default: begin
                state_n_s = e_reset;
                core_n_s  = core_zero_lp;
                step_n_s  = step_freeze_lp;
            end
        endcase

        send_s = (state_n_s == e_send_cfg) || (state_n_s == e_send_unfreeze);
        if (send_s && (credit_n_s < max_credits_lp)) begin
            cfg_v_n_s = 1'b1;
        end else begin
            cfg_v_n_s = 1'b0;
        end

        if (state_n_s == e_send_cfg) begin
            dst_n_s  = core_n_s;
            addr_n_s = cfg_addr_width_p'(step_n_s);
            data_n_s = cfg_data_f(step_n_s, core_n_s);
        end else if (state_n_s == e_send_unfreeze) begin
            dst_n_s  = core_n_s;
            addr_n_s = addr_freeze_lp;
            data_n_s = data_zero_lp;
        end else begin
            dst_n_s  = core_zero_lp;
            addr_n_s = addr_freeze_lp;
            data_n_s = data_zero_lp;
        end

        done_n_s = (state_n_s == e_done);
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= e_reset;
            core_r   <= core_zero_lp;
            step_r   <= step_freeze_lp;
            credit_r <= credit_zero_lp;
            cfg_v_r  <= 1'b0;
            dst_r    <= core_zero_lp;
            addr_r   <= addr_freeze_lp;
            data_r   <= data_zero_lp;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            core_r   <= core_n_s;
            step_r   <= step_n_s;
            credit_r <= credit_n_s;
            cfg_v_r  <= cfg_v_n_s;
            dst_r    <= dst_n_s;
            addr_r   <= addr_n_s;
            data_r   <= data_n_s;
            done_r   <= done_n_s;
        end
    end

endmodule

// -----------------------------------------------------------------------------
// bp_cfg_boot_loader_checker
//
// Watches the boot loader's credit counter. An acknowledgement consumed while
// no write is outstanding (and no transfer is occurring in the same cycle) is
// a protocol error; so is a counter above max_credits_p. Each violation bumps
// err_count_o so the surrounding environment can observe that it fired.
//
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   cfg_v_i         boot loader write valid
//   cfg_ready_i     downstream ready
//   ack_yumi_i      acknowledgement consumed by the boot loader
//   credits_i       boot loader credit counter
//   err_count_o     number of violations seen since reset
// -----------------------------------------------------------------------------
module bp_cfg_boot_loader_checker #(
    parameter int unsigned max_credits_p   = 32'd4,
    parameter int unsigned credit_width_lp = $clog2(max_credits_p + 32'd1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cfg_v_i,
    input  logic                       cfg_ready_i,
    input  logic                       ack_yumi_i,
    input  logic [credit_width_lp-1:0] credits_i,
    output logic [7:0]                 err_count_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);
    localparam logic [credit_width_lp-1:0] credit_zero_lp = {credit_width_lp{1'b0}};

    logic       spurious_ack_s;
    logic       overflow_s;
    logic [7:0] err_count_r;

    assign spurious_ack_s = ack_yumi_i & ~(cfg_v_i & cfg_ready_i) & (credits_i == credit_zero_lp);
    assign overflow_s     = (credits_i > max_credits_lp);
    assign err_count_o    = err_count_r;

    // Protocol assertions; a failure is recorded in the violation counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_count_r <= 8'd0;
        end else begin
            assert (!spurious_ack_s) else err_count_r <= err_count_r + 8'd1;
            assert (!overflow_s) else err_count_r <= err_count_r + 8'd1;
        end
    end

endmodule
